// File: rtl/gty_bringup_seq.sv
// -----------------------------------------------------------------------------
// gty_bringup_seq
//
// Bring-up and recovery sequencer for the GTY transceiver reset tree. Pulses
// reset_all, waits for QPLL lock, pulses the TX/RX datapath resets, then waits
// for both reset-done flags. Each wait phase is bounded by a timeout; a timed
// out attempt re-runs the whole sequence up to MAX_RETRIES extra times before
// parking in FAIL. Status is exported as a GPIO-readable word.
//
// Optional feature macro: GTY_SEQ_AUTO_RELOCK_EN
//   defined   : loss of QPLL lock in READY sets timeout_seen and takes the retry
//               path; entering READY clears the retry count.
//   undefined : loss of QPLL lock in READY goes straight to FAIL; the retry
//               count is kept on reaching READY.
//
// Parameters
//   SETTLE_CYCLES  : cycles each reset pulse is held high (>= 1)
//   TIMEOUT_CYCLES : cycles allowed in a wait phase before the attempt fails
//   MAX_RETRIES    : full re-sequences allowed after the first attempt (0..15)
//
// Ports
//   clk                : single clock, rising edge
//   rst                : asynchronous active-high reset
//   start              : one-cycle request, honoured in IDLE, READY and FAIL
//   abort              : one-cycle request, forces IDLE from any state
//   gty_slow_flags_in  : [0] qpll_lock, [1] tx_reset_done, [2] rx_reset_done
//                        (asynchronous to clk; other bits ignored)
//   gty_slow_flags_out : [0] reset_all, [1] reset_tx_datapath,
//                        [2] reset_rx_datapath; other bits 0
//   gpio_out           : [2:0] state, [6:3] retry count, [7] busy, [8] ready,
//                        [9] fail, [10] timeout_seen; other bits 0
//
// States
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | 0: quiescent, all resets low, waiting for start
//   RST_ALL   | 1: reset_all held high for SETTLE_CYCLES
//   WAIT_PLL  | 2: waiting for synchronized qpll_lock (timeout bounded)
//   RST_DP    | 3: TX/RX datapath resets held high for SETTLE_CYCLES
//   WAIT_DONE | 4: waiting for tx/rx reset_done (timeout bounded)
//   READY     | 5: link reset tree up, lock monitored
//   FAIL      | 6: retries exhausted (or lock lost), resets low
// -----------------------------------------------------------------------------
module gty_bringup_seq #(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] gty_slow_flags_in,
  output logic [31:0] gty_slow_flags_out,
  output logic [31:0] gpio_out
);

  // The shared phase counter must be able to reach both the settle and the
  // timeout terminal values; normally TIMEOUT_CYCLES is the larger one and
  // the counter saturates there.
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                                    TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_ALL   = 3'd1,
    WAIT_PLL  = 3'd2,
    RST_DP    = 3'd3,
    WAIT_DONE = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer for the three status flags used by the FSM
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q1;
  logic [2:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gty_slow_flags_in[2:0];
      sync_q2 <= sync_q1;
    end
  end

  logic pll_lock;
  logic tx_done;
  logic rx_done;

  assign pll_lock = sync_q2[0];
  assign tx_done  = sync_q2[1];
  assign rx_done  = sync_q2[2];

  logic unused_flags;
  assign unused_flags = ^gty_slow_flags_in[31:3];

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_cnt_nxt;
  logic [3:0]       retry_cnt;
  logic [3:0]       retry_nxt;
  logic             timeout_seen;
  logic             timeout_nxt;
  logic             retry_req;

  logic             reset_all_q;
  logic             reset_dp_q;
  logic             busy_q;
  logic             ready_q;
  logic             fail_q;

  logic             start_ok;

  assign start_ok = start && ((state == IDLE) || (state == READY) || (state == FAIL));

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry_cnt;
    timeout_nxt = timeout_seen;
    retry_req   = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
    end else if (start_ok) begin
      state_nxt   = RST_ALL;
      retry_nxt   = '0;
      timeout_nxt = 1'b0;
    end else begin
      case (state)
        RST_ALL: begin
          if (phase_cnt == SETTLE_LAST) state_nxt = WAIT_PLL;
        end
        WAIT_PLL: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (pll_lock)                        state_nxt = RST_DP;
          else if (phase_cnt == TIMEOUT_LAST)  retry_req = 1'b1;
        end
        RST_DP: begin
          if (phase_cnt == SETTLE_LAST) state_nxt = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done && rx_done)              state_nxt = READY;
          else if (phase_cnt == TIMEOUT_LAST)  retry_req = 1'b1;
        end
        READY: begin
          if (!pll_lock) begin
`ifdef GTY_SEQ_AUTO_RELOCK_EN
            retry_req = 1'b1;
`else
            state_nxt = FAIL;
`endif
          end
        end
        IDLE, FAIL: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      if (retry_req) begin
        timeout_nxt = 1'b1;
        if (retry_cnt < RETRY_LIMIT) begin
          state_nxt = RST_ALL;
          if (retry_cnt != 4'hF) retry_nxt = retry_cnt + 4'd1;
        end else begin
          state_nxt = FAIL;
        end
      end

`ifdef GTY_SEQ_AUTO_RELOCK_EN
      // A successful (re)lock starts a fresh retry budget.
      if ((state_nxt == READY) && (state != READY)) retry_nxt = '0;
`endif
    end
  end

  // The phase counter restarts on every state change and otherwise counts up,
  // holding at its saturation value in the long-lived states.
  always_comb begin
    if (state_nxt != state)      phase_cnt_nxt = '0;
    else if (phase_cnt == CNT_SAT) phase_cnt_nxt = phase_cnt;
    else                         phase_cnt_nxt = phase_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      retry_cnt    <= '0;
      timeout_seen <= 1'b0;
      reset_all_q  <= 1'b0;
      reset_dp_q   <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase_cnt    <= phase_cnt_nxt;
      retry_cnt    <= retry_nxt;
      timeout_seen <= timeout_nxt;
      // Output flags are registered from the next state so they line up
      // exactly with the state register.
      reset_all_q  <= (state_nxt == RST_ALL);
      reset_dp_q   <= (state_nxt == RST_DP);
      busy_q       <= (state_nxt == RST_ALL) || (state_nxt == WAIT_PLL) ||
                      (state_nxt == RST_DP)  || (state_nxt == WAIT_DONE);
      ready_q      <= (state_nxt == READY);
      fail_q       <= (state_nxt == FAIL);
    end
  end

  logic [2:0] state_code;
  assign state_code = state;

  assign gty_slow_flags_out = {29'b0, reset_dp_q, reset_dp_q, reset_all_q};
  assign gpio_out           = {21'b0, timeout_seen, fail_q, ready_q, busy_q,
                               retry_cnt, state_code};

endmodule

// File: tb/tb_gty_bringup_seq.sv
// Directed bench for gty_bringup_seq with SETTLE_CYCLES=8, TIMEOUT_CYCLES=100,
// MAX_RETRIES=2. Inputs change and outputs are sampled 1 ns after the rising
// edge.
module tb_gty_bringup_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] gty_slow_flags_in;
  logic [31:0] gty_slow_flags_out;
  logic [31:0] gpio_out;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int n;

  gty_bringup_seq #(
    .SETTLE_CYCLES (8),
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES   (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .gty_slow_flags_in (gty_slow_flags_in),
    .gty_slow_flags_out(gty_slow_flags_out),
    .gpio_out          (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int cycles = 1);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Count consecutive sampled cycles with the given output flag high.
  task automatic measure_flag(input int b, output int cnt);
    cnt = 0;
    while (gty_slow_flags_out[b] && cnt < 300) begin
      cnt++;
      step();
    end
  endtask

  // Count consecutive sampled cycles spent in the given state.
  task automatic measure_state(input logic [2:0] st, output int cnt);
    cnt = 0;
    while (gpio_out[2:0] == st && cnt < 300) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    gty_slow_flags_in = 32'h0;
    #22;
    check("reset_gpio", gpio_out, 32'h0);
    check("reset_flags_out", gty_slow_flags_out, 32'h0);
    rst = 1'b0;
    step();

    // Nominal bring-up: lock 20 cycles after start, dones 30 cycles later.
    pulse_start();
    check("nom_start_gpio", gpio_out, 32'h81);
    check("nom_rst_all_out", gty_slow_flags_out, 32'h1);
    measure_flag(0, n);
    check("nom_rst_all_width", n, 8);
    check("nom_wait_pll", gpio_out, 32'h82);
    step(12);
    gty_slow_flags_in = 32'h1;
    step(2);
    check("nom_sync_latency", gpio_out[2:0], 3'd2);
    step();
    check("nom_rst_dp_state", gpio_out[2:0], 3'd3);
    check("nom_rst_dp_out", gty_slow_flags_out, 32'h6);
    measure_flag(1, n);
    check("nom_rst_dp_width", n, 8);
    check("nom_wait_done", gpio_out[2:0], 3'd4);
    step(20);
    gty_slow_flags_in = 32'h7;
    step(3);
    check("nom_ready_gpio", gpio_out, 32'h105);
    check("nom_ready_out", gty_slow_flags_out, 32'h0);

    // Persistent timeout: three 100-cycle WAIT_PLL attempts, then FAIL.
    gty_slow_flags_in = 32'h0;
    pulse_start();
    check("to_start_gpio", gpio_out, 32'h81);
    step(8);
    measure_state(3'd2, n);
    check("to_wait1_len", n, 100);
    check("to_retry1_gpio", gpio_out, 32'h489);
    step(8);
    measure_state(3'd2, n);
    check("to_wait2_len", n, 100);
    check("to_retry2_gpio", gpio_out, 32'h491);
    step(8);
    measure_state(3'd2, n);
    check("to_wait3_len", n, 100);
    check("to_fail_gpio", gpio_out, 32'h616);
    check("to_fail_out", gty_slow_flags_out, 32'h0);

    // Lock arrives during the second attempt.
    pulse_start();
    check("late_start_gpio", gpio_out, 32'h81);
    step(108);
    check("late_retry_gpio", gpio_out, 32'h489);
    step(8);
    step(10);
    gty_slow_flags_in = 32'h1;
    step(3);
    check("late_rst_dp", gpio_out[2:0], 3'd3);
    step(8);
    check("late_wait_done", gpio_out[2:0], 3'd4);
    gty_slow_flags_in = 32'h7;
    step(3);
`ifdef GTY_SEQ_AUTO_RELOCK_EN
    check("late_ready_gpio", gpio_out, 32'h505);
`else
    check("late_ready_gpio", gpio_out, 32'h50d);
`endif

    // Abort during RST_DP after one retry, then a clean restart.
    gty_slow_flags_in = 32'h0;
    pulse_start();
    step(108);
    check("abort_retry_gpio", gpio_out, 32'h489);
    gty_slow_flags_in = 32'h1;
    step(9);
    check("abort_in_rst_dp", gpio_out[2:0], 3'd3);
    step(2);
    pulse_abort();
    check("abort_out", gty_slow_flags_out, 32'h0);
    check("abort_state_busy", gpio_out[7:0] & 32'h87, 32'h0);
    gty_slow_flags_in = 32'h7;
    pulse_start();
    check("clean_start_gpio", gpio_out, 32'h81);
    measure_flag(0, n);
    check("clean_rst_all_width", n, 8);
    step();
    check("clean_rst_dp_state", gpio_out[2:0], 3'd3);
    measure_flag(1, n);
    check("clean_rst_dp_width", n, 8);
    step();
    check("clean_ready_gpio", gpio_out, 32'h105);

    // Loss of lock in READY.
    gty_slow_flags_in = 32'h6;
    step(3);
`ifdef GTY_SEQ_AUTO_RELOCK_EN
    check("lol_relock_gpio", gpio_out, 32'h489);
    check("lol_relock_out", gty_slow_flags_out, 32'h1);
`else
    check("lol_fail_gpio", gpio_out, 32'h206);
    check("lol_fail_out", gty_slow_flags_out, 32'h0);
`endif

    // Asynchronous reset mid-WAIT_DONE.
    gty_slow_flags_in = 32'h1;
    pulse_abort();
    pulse_start();
    check("arst_start_gpio", gpio_out, 32'h81);
    step(9);
    check("arst_rst_dp", gpio_out[2:0], 3'd3);
    step(8);
    check("arst_wait_done", gpio_out[2:0], 3'd4);
    step(5);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_async", gty_slow_flags_out, 32'h0);
    check("arst_gpio_async", gpio_out, 32'h0);
    #2;
    rst = 1'b0;
    gty_slow_flags_in = 32'h7;
    step(5);
    check("arst_idle_gpio", gpio_out, 32'h0);
    check("arst_idle_out", gty_slow_flags_out, 32'h0);
    pulse_start();
    check("arst_restart_gpio", gpio_out, 32'h81);
    measure_flag(0, n);
    check("arst_restart_width", n, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
